// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe auto player and win checker.
package ttt_pkg;

  typedef enum logic [1:0] {
    P0      = 2'd0,
    P1      = 2'd1,
    BLOCKED = 2'd2,
    EMPTY   = 2'd3
  } cell_t;

  localparam logic [1:0] NO_PLAYER   = 2'd3;
  localparam int         BOARD_CELLS = 9;

  // Rows, columns, then the two diagonals; cell index = y*3+x.
  localparam int WIN_LINES [8][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

  // Returns {y, x}, three bits each.
  function automatic logic [5:0] idx_to_xy(input logic [3:0] idx);
    case (idx)
      4'd0:    return {3'd0, 3'd0};
      4'd1:    return {3'd0, 3'd1};
      4'd2:    return {3'd0, 3'd2};
      4'd3:    return {3'd1, 3'd0};
      4'd4:    return {3'd1, 3'd1};
      4'd5:    return {3'd1, 3'd2};
      4'd6:    return {3'd2, 3'd0};
      4'd7:    return {3'd2, 3'd1};
      4'd8:    return {3'd2, 3'd2};
      default: return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/ttt_win_check.sv
// Combinational line and fullness evaluation of a 9-cell board (2 bits per cell).
module ttt_win_check
  import ttt_pkg::*;
(
  input  logic [2*BOARD_CELLS-1:0] board,
  input  logic [1:0]               player,
  output logic                     win,
  output logic                     board_full
);

  always_comb begin
    win        = 1'b0;
    board_full = 1'b1;
    // BLOCKED/EMPTY codes are never a player, so they cannot form a line.
    for (int l = 0; l < 8; l++) begin
      if (!player[1] &&
          board[2*WIN_LINES[l][0] +: 2] == player &&
          board[2*WIN_LINES[l][1] +: 2] == player &&
          board[2*WIN_LINES[l][2] +: 2] == player)
        win = 1'b1;
    end
    for (int i = 0; i < BOARD_CELLS; i++) begin
      if (board[2*i +: 2] == EMPTY)
        board_full = 1'b0;
    end
  end

endmodule

// File: rtl/ttt_auto_player.sv
// Self-playing move source: alternates players, scans for the first free cell, stops on win/draw/abort.
module ttt_auto_player
  import ttt_pkg::*;
#(
  parameter int MOVE_GAP = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] first_player,
  input  logic [8:0] block_mask,
  input  logic       stop_game,
  output logic       move_en,
  output logic [2:0] move_x,
  output logic [2:0] move_y,
  output logic [1:0] move_player,
  output logic       busy,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [3:0] move_count
);

  typedef enum logic [2:0] {IDLE, SCAN, ISSUE, CHECK, GAP, DONE} state_t;

  state_t                   state;
  logic [2*BOARD_CELLS-1:0] shadow;
  logic [1:0]               cur;
  logic [3:0]               idx;
  logic [3:0]               gap_cnt;
  logic                     win;
  logic                     board_full;
  logic [5:0]               xy;

  assign xy = idx_to_xy(idx);

  ttt_win_check u_win_check (
    .board      (shadow),
    .player     (cur),
    .win        (win),
    .board_full (board_full)
  );

  function automatic logic [2*BOARD_CELLS-1:0] mask_to_board(input logic [8:0] m);
    logic [2*BOARD_CELLS-1:0] b;
    for (int i = 0; i < BOARD_CELLS; i++)
      b[2*i +: 2] = m[i] ? BLOCKED : EMPTY;
    return b;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shadow      <= '1;
      cur         <= 2'd0;
      idx         <= 4'd0;
      gap_cnt     <= 4'd0;
      move_en     <= 1'b0;
      move_x      <= 3'd0;
      move_y      <= 3'd0;
      move_player <= NO_PLAYER;
      busy        <= 1'b0;
      game_over   <= 1'b0;
      winner      <= NO_PLAYER;
      move_count  <= 4'd0;
    end else begin
      move_en     <= 1'b0;
      move_player <= NO_PLAYER;
      case (state)
        IDLE, DONE: begin
          if (start && !first_player[1]) begin
            shadow     <= mask_to_board(block_mask);
            cur        <= first_player;
            move_count <= 4'd0;
            winner     <= NO_PLAYER;
            idx        <= first_player[0] ? 4'd8 : 4'd0;
            if (&block_mask) begin
              state     <= DONE;
              game_over <= 1'b1;
              busy      <= 1'b0;
            end else begin
              state     <= SCAN;
              game_over <= 1'b0;
              busy      <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (stop_game) begin
            state <= DONE; busy <= 1'b0; game_over <= 1'b1; winner <= NO_PLAYER;
          end else if (shadow[2*idx +: 2] == EMPTY) begin
            state       <= ISSUE;
            move_en     <= 1'b1;
            move_x      <= xy[2:0];
            move_y      <= xy[5:3];
            move_player <= cur;
          end else begin
            idx <= cur[0] ? idx - 4'd1 : idx + 4'd1;
          end
        end
        // The strobe is already on the wire during ISSUE, so an abort here still books the move.
        ISSUE: begin
          shadow[2*idx +: 2] <= cur;
          move_count         <= move_count + 4'd1;
          if (stop_game) begin
            state <= DONE; busy <= 1'b0; game_over <= 1'b1; winner <= NO_PLAYER;
          end else begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (stop_game) begin
            state <= DONE; busy <= 1'b0; game_over <= 1'b1; winner <= NO_PLAYER;
          end else if (win) begin
            state <= DONE; busy <= 1'b0; game_over <= 1'b1; winner <= cur;
          end else if (board_full) begin
            state <= DONE; busy <= 1'b0; game_over <= 1'b1; winner <= NO_PLAYER;
          end else begin
            cur <= {1'b0, ~cur[0]};
            idx <= cur[0] ? 4'd0 : 4'd8;
            if (MOVE_GAP > 0) begin
              state   <= GAP;
              gap_cnt <= 4'(MOVE_GAP - 1);
            end else begin
              state <= SCAN;
            end
          end
        end
        GAP: begin
          if (stop_game) begin
            state <= DONE; busy <= 1'b0; game_over <= 1'b1; winner <= NO_PLAYER;
          end else if (gap_cnt == 4'd0) begin
            state <= SCAN;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ttt_auto_player.sv
// Scoreboard bench for ttt_auto_player: directed games on a MOVE_GAP=0 and a MOVE_GAP=2 instance.
module tb_ttt_auto_player;

  typedef struct {int x; int y; int p; int cyc;} mv_t;
  typedef struct {int winner; int count; int cyc;} end_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic       start0, stop0, start2, stop2;
  logic [1:0] fp0, fp2;
  logic [8:0] mask0, mask2;
  logic       en0, en2, busy0, busy2, go0, go2;
  logic [2:0] x0, y0, x2, y2;
  logic [1:0] p0, p2, win0, win2;
  logic [3:0] cnt0, cnt2;

  ttt_auto_player #(.MOVE_GAP(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .first_player(fp0), .block_mask(mask0),
    .stop_game(stop0), .move_en(en0), .move_x(x0), .move_y(y0), .move_player(p0),
    .busy(busy0), .game_over(go0), .winner(win0), .move_count(cnt0));

  ttt_auto_player #(.MOVE_GAP(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .first_player(fp2), .block_mask(mask2),
    .stop_game(stop2), .move_en(en2), .move_x(x2), .move_y(y2), .move_player(p2),
    .busy(busy2), .game_over(go2), .winner(win2), .move_count(cnt2));

  mv_t  mq0[$], mq2[$];
  end_t eq0[$], eq2[$];
  mv_t  m0, m2;
  end_t e0, e2;
  logic pgo0 = 1'b0, pgo2 = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitors: every strobe and every entry into game_over is matched against the queues.
  always @(negedge clk) begin
    if (en0) begin
      if (mq0.size() == 0) chk("dut0 unexpected move_en", 1, 0);
      else begin
        m0 = mq0.pop_front();
        chk("dut0 move_x", x0, m0.x);
        chk("dut0 move_y", y0, m0.y);
        chk("dut0 move_player", p0, m0.p);
        chk("dut0 move cycle", cyc, m0.cyc);
      end
    end
    if (go0 && !pgo0) begin
      if (eq0.size() == 0) chk("dut0 unexpected game_over", 1, 0);
      else begin
        e0 = eq0.pop_front();
        chk("dut0 winner", win0, e0.winner);
        chk("dut0 move_count", cnt0, e0.count);
        chk("dut0 done cycle", cyc, e0.cyc);
      end
    end
    pgo0 <= go0;
  end

  always @(negedge clk) begin
    if (en2) begin
      if (mq2.size() == 0) chk("dut2 unexpected move_en", 1, 0);
      else begin
        m2 = mq2.pop_front();
        chk("dut2 move_x", x2, m2.x);
        chk("dut2 move_y", y2, m2.y);
        chk("dut2 move_player", p2, m2.p);
        chk("dut2 move cycle", cyc, m2.cyc);
      end
    end
    if (go2 && !pgo2) begin
      if (eq2.size() == 0) chk("dut2 unexpected game_over", 1, 0);
      else begin
        e2 = eq2.pop_front();
        chk("dut2 winner", win2, e2.winner);
        chk("dut2 move_count", cnt2, e2.count);
        chk("dut2 done cycle", cyc, e2.cyc);
      end
    end
    pgo2 <= go2;
  end

  task automatic wait_empty();
    int n = 0;
    while ((mq0.size() + mq2.size() + eq0.size() + eq2.size()) != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (n >= 300) begin
      chk("scoreboard drain timeout", 0, 1);
      mq0.delete(); mq2.delete(); eq0.delete(); eq2.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " move_en"}, en0, 0);
    chk({tag, " move_x"}, x0, 0);
    chk({tag, " move_y"}, y0, 0);
    chk({tag, " move_player"}, p0, 3);
    chk({tag, " busy"}, busy0, 0);
    chk({tag, " game_over"}, go0, 0);
    chk({tag, " winner"}, win0, 3);
    chk({tag, " move_count"}, cnt0, 0);
  endtask

  // Full game on the gap-0 instance; cells/skips list each move's index and cells scanned past.
  task automatic play(input int fp, input logic [8:0] mask, input int cells[$],
                      input int skips[$], input int win, input bit inject);
    int   k, t, p;
    mv_t  mv;
    end_t ev;
    @(posedge clk); #1;
    start0 = 1'b1; fp0 = fp[1:0]; mask0 = mask;
    k = cyc;
    t = k + 2;
    p = fp;
    foreach (cells[i]) begin
      t += skips[i];
      mv.x = cells[i] % 3; mv.y = cells[i] / 3; mv.p = p; mv.cyc = t;
      mq0.push_back(mv);
      p ^= 1;
      if (i < cells.size() - 1) t += 3;
    end
    ev.winner = win; ev.count = cells.size(); ev.cyc = t + 2;
    eq0.push_back(ev);
    @(posedge clk); #1;
    start0 = 1'b0;
    if (inject) begin
      repeat (3) @(posedge clk);
      #1; start0 = 1'b1; fp0 = 2'd1; mask0 = 9'h0FF;
      @(posedge clk); #1; start0 = 1'b0;
    end
    wait_empty();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int   k;
    mv_t  mv;
    end_t ev;
    reset = 1'b1;
    start0 = 1'b0; stop0 = 1'b0; fp0 = 2'd0; mask0 = 9'h0;
    start2 = 1'b0; stop2 = 1'b0; fp2 = 2'd0; mask2 = 9'h0;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    check_reset_vals("reset");
    chk("dut2 reset move_player", p2, 3);

    play(0, 9'h000, '{0, 8, 1, 7, 2}, '{0, 0, 1, 1, 2}, 0, 1'b0);
    play(1, 9'h000, '{8, 0, 7, 1, 6}, '{0, 0, 1, 1, 2}, 1, 1'b0);
    play(0, 9'b001_010_100, '{0, 8, 1, 7, 3, 5}, '{0, 0, 1, 1, 3, 3}, 3, 1'b0);
    chk("draw game_over held", go0, 1);
    chk("draw busy low", busy0, 0);

    // Gap instance: two moves 5 cycles apart, then abort inside the gap.
    @(posedge clk); #1;
    start2 = 1'b1; fp2 = 2'd0; mask2 = 9'h000;
    k = cyc;
    mv.x = 0; mv.y = 0; mv.p = 0; mv.cyc = k + 2; mq2.push_back(mv);
    mv.x = 2; mv.y = 2; mv.p = 1; mv.cyc = k + 7; mq2.push_back(mv);
    @(posedge clk); #1;
    start2 = 1'b0;
    repeat (8) @(posedge clk);
    #1; stop2 = 1'b1;
    ev.winner = 3; ev.count = 2; ev.cyc = k + 10; eq2.push_back(ev);
    @(posedge clk); #1; stop2 = 1'b0;
    wait_empty();
    repeat (20) @(posedge clk);
    #1;
    chk("dut2 abort busy", busy2, 0);
    chk("dut2 abort game_over", go2, 1);

    // Fully blocked board straight after reset.
    reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1;
    start0 = 1'b1; fp0 = 2'd0; mask0 = 9'h1FF;
    k = cyc;
    ev.winner = 3; ev.count = 0; ev.cyc = k + 1; eq0.push_back(ev);
    @(posedge clk); #1; start0 = 1'b0;
    wait_empty();
    chk("full mask busy", busy0, 0);

    play(0, 9'h001, '{1, 8, 2, 7, 3, 6}, '{1, 0, 2, 1, 3, 2}, 1, 1'b0);

    // Invalid first_player is ignored: no strobe, still in DONE.
    @(posedge clk); #1;
    start0 = 1'b1; fp0 = 2'd2; mask0 = 9'h000;
    @(posedge clk); #1; start0 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("bad first_player busy", busy0, 0);
    chk("bad first_player count", cnt0, 6);

    // Reset while scanning, then the first game again with a start pulse mid-game.
    @(posedge clk); #1;
    start0 = 1'b1; fp0 = 2'd0; mask0 = 9'h000;
    @(posedge clk); #1;
    start0 = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("mid-game reset");
    reset = 1'b0;
    repeat (3) @(posedge clk);
    play(0, 9'h000, '{0, 8, 1, 7, 2}, '{0, 0, 1, 1, 2}, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
